// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int MEM_LAT_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; remembers the last winner so contention alternates.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_grant_valid,
  output logic o_grant_id,
  output logic o_last_grant
);
  logic r_last;
  logic w_gid;

  always_comb begin
    w_gid = REQ_CPU;
    if (i_req0 && i_req1) w_gid = ~r_last;
    else if (i_req1)      w_gid = REQ_DMA;
  end

  // Reset to DMA so the CPU wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_last <= REQ_DMA;
    else if (i_en && o_grant_valid)  r_last <= w_gid;
  end

  assign o_grant_valid = i_req0 | i_req1;
  assign o_grant_id    = w_gid;
  assign o_last_grant  = r_last;
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto one fixed-latency memory port,
// returning a one-cycle ready pulse (with read data) to the granted requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_cpu_ready;
  logic              r_dma_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_gvalid;
  logic              w_gid;
  logic              w_last;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [DATA_W-1:0] w_resp_data;

  rr_arbiter2 u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_en          (r_state == IDLE),
    .i_req0        (cpu_req),
    .i_req1        (dma_req),
    .o_grant_valid (w_gvalid),
    .o_grant_id    (w_gid),
    .o_last_grant  (w_last)
  );

  assign w_sel_we    = (w_gid == REQ_DMA) ? dma_we    : cpu_we;
  assign w_sel_addr  = (w_gid == REQ_DMA) ? dma_addr  : cpu_addr;
  assign w_sel_wdata = (w_gid == REQ_DMA) ? dma_wdata : cpu_wdata;
  // Writes return the last read value held in r_rdata, reads the live memory data.
  assign w_resp_data = r_we ? r_rdata : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gvalid) begin
            r_we        <= w_sel_we;
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_cnt       <= CNT_INIT;
            r_mem_read  <= ~w_sel_we;
            r_mem_write <= w_sel_we;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (!r_we) r_rdata <= mem_rdata;
            r_cpu_ready <= (w_last == REQ_CPU);
            r_dma_ready <= (w_last == REQ_DMA);
            r_cpu_rdata <= (w_last == REQ_CPU) ? w_resp_data : '0;
            r_dma_rdata <= (w_last == REQ_DMA) ? w_resp_data : '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_cpu_ready <= 1'b0;
          r_dma_ready <= 1'b0;
          r_cpu_rdata <= '0;
          r_dma_rdata <= '0;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_cpu_ready <= 1'b0;
          r_dma_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready = r_cpu_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_ready = r_dma_ready;
  assign dma_rdata = r_dma_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == ACCESS) || (r_state == RESP);
  assign grant_id  = w_last;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [11:0] cpu_addr = 0, dma_addr = 0;
  logic [15:0] cpu_wdata = 0, dma_wdata = 0;
  logic        cpu_ready, dma_ready, mem_read, mem_write, busy, grant_id;
  logic [15:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic        c1_req = 0;
  logic [11:0] c1_addr = 0;
  logic        c1_ready, d1_ready, m1_read, m1_write, busy1, gid1;
  logic [15:0] c1_rdata, d1_rdata, m1_wdata, m1_rdata;
  logic [11:0] m1_addr;

  logic [15:0] mem [0:4095];
  logic [16:0] exp_cpu[$], exp_dma[$], exp1[$];
  logic [16:0] mon_e;
  logic        prev_cpu = 0, prev_dma = 0, prev_c1 = 0;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0),
    .cpu_ready(c1_ready), .cpu_rdata(c1_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(12'h0), .dma_wdata(16'h0),
    .dma_ready(d1_ready), .dma_rdata(d1_rdata),
    .mem_read(m1_read), .mem_write(m1_write), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .busy(busy1), .grant_id(gid1)
  );

  // Memory model: combinational read, write on the clock edge; preload while in reset.
  always @(posedge clk) begin
    if (reset) mem[12'h010] <= 16'hBEEF;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];
  assign m1_rdata  = mem[m1_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected response whenever a ready pulse appears.
  always @(negedge clk) begin
    if (reset) begin
      prev_cpu = 0; prev_dma = 0; prev_c1 = 0;
    end else begin
      if (cpu_ready) begin
        chk("cpu_pulse_width", {31'd0, prev_cpu}, 0);
        chk("cpu_grant_id", {31'd0, grant_id}, 0);
        chk("cpu_excl_ready", {31'd0, dma_ready}, 0);
        chk("cpu_other_rdata", {16'd0, dma_rdata}, 0);
        if (exp_cpu.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL cpu_unexpected_ready: got ready=1 expected none");
        end else begin
          mon_e = exp_cpu.pop_front();
          if (mon_e[16]) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, mon_e[15:0]});
        end
      end
      if (dma_ready) begin
        chk("dma_pulse_width", {31'd0, prev_dma}, 0);
        chk("dma_grant_id", {31'd0, grant_id}, 1);
        chk("dma_other_rdata", {16'd0, cpu_rdata}, 0);
        if (exp_dma.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL dma_unexpected_ready: got ready=1 expected none");
        end else begin
          mon_e = exp_dma.pop_front();
          if (mon_e[16]) chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, mon_e[15:0]});
        end
      end
      if (c1_ready) begin
        chk("lat1_pulse_width", {31'd0, prev_c1}, 0);
        chk("lat1_dma_ready", {31'd0, d1_ready}, 0);
        chk("lat1_dma_rdata", {16'd0, d1_rdata}, 0);
        if (exp1.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL lat1_unexpected_ready: got ready=1 expected none");
        end else begin
          mon_e = exp1.pop_front();
          chk("lat1_rdata", {16'd0, c1_rdata}, {16'd0, mon_e[15:0]});
        end
      end
      prev_cpu = cpu_ready; prev_dma = dma_ready; prev_c1 = c1_ready;
    end
  end

  // Single isolated access on the MEM_LAT=2 instance; call at posedge+1.
  task automatic access(input bit dma, input bit we, input logic [11:0] a,
                        input logic [15:0] wd, input logic [15:0] ed, input string nm);
    int n = 0;
    int cyc = 0;
    bit got = 0;
    if (dma) begin
      dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd; exp_dma.push_back({~we, ed});
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; exp_cpu.push_back({~we, ed});
    end
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (we ? mem_write : mem_read) n++;
      if (dma ? dma_ready : cpu_ready) got = 1;
    end
    chk({nm, "_done"}, {31'd0, got}, 1);
    chk({nm, "_strobe_cycles"}, n, 2);
    tick();
    cpu_req = 0; dma_req = 0;
  endtask

  // Both requesters hold reads; record the order and spacing of ready pulses.
  task automatic contend(input int n, input string nm);
    int ids[$];
    int at[$];
    int cyc = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    dma_req = 1; dma_we = 0; dma_addr = 12'h020;
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 0) exp_cpu.push_back({1'b1, 16'hBEEF});
      else            exp_dma.push_back({1'b1, 16'h1234});
    end
    while (ids.size() < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) begin ids.push_back(0); at.push_back(cyc); end
      if (dma_ready) begin ids.push_back(1); at.push_back(cyc); end
    end
    chk({nm, "_count"}, ids.size(), n);
    tick();
    cpu_req = 0; dma_req = 0;
    for (int i = 0; i < ids.size(); i++) begin
      chk($sformatf("%s_order%0d", nm, i), ids[i], i % 2);
      if (i > 0) chk($sformatf("%s_spacing%0d", nm, i), at[i] - at[i-1], 4);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_grant_id", {31'd0, grant_id}, 1);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
    chk("rst_ready", {30'd0, cpu_ready, dma_ready}, 0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 0);

    // Isolated CPU read, cycle by cycle.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    exp_cpu.push_back({1'b1, 16'hBEEF});
    @(negedge clk); chk("t1_c0_read", {31'd0, mem_read}, 0);
    tick(); @(negedge clk);
    chk("t1_c1_read", {31'd0, mem_read}, 1);
    chk("t1_c1_addr", {20'd0, mem_addr}, 32'h010);
    chk("t1_c1_busy", {31'd0, busy}, 1);
    tick(); @(negedge clk);
    chk("t1_c2_read", {31'd0, mem_read}, 1);
    chk("t1_c2_ready", {31'd0, cpu_ready}, 0);
    tick(); @(negedge clk);
    chk("t1_c3_ready", {31'd0, cpu_ready}, 1);
    chk("t1_c3_read", {31'd0, mem_read}, 0);
    chk("t1_c3_dma_ready", {31'd0, dma_ready}, 0);
    tick();
    cpu_req = 0;
    @(negedge clk); chk("t1_c4_busy", {31'd0, busy}, 0);
    tick();

    // DMA write then CPU read-back.
    access(1, 1, 12'h020, 16'h1234, 16'h0000, "t2_dma_wr");
    access(0, 0, 12'h020, 16'h0000, 16'h1234, "t2_cpu_rd");

    // Contention from reset alternates CPU, DMA, CPU, DMA.
    reset = 1; tick(); reset = 0;
    contend(4, "t3");

    // Requester address changes mid-access must not reach the memory.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
    exp_cpu.push_back({1'b1, 16'hBEEF});
    tick();
    cpu_addr = 12'h3FF;
    @(negedge clk); chk("t4_c1_addr", {20'd0, mem_addr}, 32'h010);
    tick(); @(negedge clk); chk("t4_c2_addr", {20'd0, mem_addr}, 32'h010);
    tick(); @(negedge clk); chk("t4_c3_ready", {31'd0, cpu_ready}, 1);
    tick();
    cpu_req = 0;

    // Reset during the first ACCESS cycle of a DMA write.
    dma_req = 1; dma_we = 1; dma_addr = 12'h030; dma_wdata = 16'h5555;
    tick();
    chk("t5_write_before_rst", {31'd0, mem_write}, 1);
    dma_req = 0;
    #2 reset = 1;
    #1;
    chk("t5_write_async_drop", {31'd0, mem_write}, 0);
    chk("t5_busy_after_rst", {31'd0, busy}, 0);
    chk("t5_gid_after_rst", {31'd0, grant_id}, 1);
    tick();
    reset = 0;
    repeat (3) @(negedge clk);
    chk("t5_idle_no_write", {30'd0, mem_write, busy}, 0);
    tick();
    contend(2, "t5");

    // MEM_LAT=1 instance: isolated CPU read.
    c1_req = 1; c1_addr = 12'h010;
    exp1.push_back({1'b1, 16'hBEEF});
    @(negedge clk); chk("t6_c0_busy", {31'd0, busy1}, 0);
    tick(); @(negedge clk);
    chk("t6_c1_read", {31'd0, m1_read}, 1);
    chk("t6_c1_busy", {31'd0, busy1}, 1);
    chk("t6_c1_ready", {31'd0, c1_ready}, 0);
    chk("t6_c1_gid", {31'd0, gid1}, 0);
    tick(); @(negedge clk);
    chk("t6_c2_read", {31'd0, m1_read}, 0);
    chk("t6_c2_ready", {31'd0, c1_ready}, 1);
    chk("t6_c2_busy", {31'd0, busy1}, 1);
    chk("t6_c2_write", {15'd0, m1_write, m1_wdata}, 0);
    tick();
    c1_req = 0;
    @(negedge clk); chk("t6_c3_busy", {31'd0, busy1}, 0);

    repeat (2) @(negedge clk);
    chk("sb_drain", exp_cpu.size() + exp_dma.size() + exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters: the multicycle CPU (requester 0) and the boot loader/DMA engine (requester 1).
- Serialises accesses and applies round-robin arbitration when both requesters contend.
- Drives fixed-latency memory strobes and returns a one-cycle ready pulse with read data.
- Sits between the CPU control/datapath memory interface and the memory array. The CPU FSM stalls in its fetch/load/store states until it sees cpu_ready.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 16, data width.
- MEM_LAT, 2, memory access cycles (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ready  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready = 1.
- dma_req  in  1  DMA request; held high until dma_ready.
- dma_we  in  1  DMA write enable.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_ready  out  1  one-cycle completion pulse to the DMA.
- dma_rdata  out  DATA_W  read data; valid only while dma_ready = 1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle.
- busy  out  1  high in ACCESS and RESP.
- grant_id  out  1  0 = CPU, 1 = DMA; value of the current or most recent grant.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, all strobes and ready outputs = 0, mem_addr/mem_wdata/rdata registers = 0, busy = 0.
  - last_grant = 1, so the CPU wins the first contention; grant_id = 1.
  - Reset mid-access drops the strobes at once and loses the transaction; the requester must re-issue it.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On grant, register we/addr/wdata of the winner, set grant_id and last_grant to the winner, load cnt = MEM_LAT-1, and go to ACCESS.
- ACCESS:
  - mem_read = ~we_r, mem_write = we_r. mem_addr and mem_wdata are driven from the registers and are stable for all MEM_LAT cycles.
  - cnt decrements each cycle. When cnt = 0, capture mem_rdata into rdata_r (reads only) and go to RESP.
  - Requester inputs are ignored during ACCESS, so changes to them cannot corrupt the access in flight.
- RESP (exactly 1 cycle):
  - The granted requester's ready = 1 and its rdata = rdata_r. The other requester's ready = 0 and its rdata = 0.
  - Strobes = 0. Next state is IDLE.
- Latency: req high in IDLE at cycle 0 → strobes in cycles 1..MEM_LAT → ready in cycle MEM_LAT+1. Back-to-back accesses from one requester therefore occupy MEM_LAT+2 cycles each.
- Requester rule: deassert req, or present the next request, on the edge after ready. The IDLE cycle re-samples req, so a req that stays high is treated as a new access.
- Starvation-free: with both requesters continuously requesting, grants alternate CPU, DMA, CPU, DMA, ...
- A write followed by a read to the same address returns the written data; no bypass is required because accesses are serialised.
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - requester ID constants REQ_CPU = 1'b0 and REQ_DMA = 1'b1;
  - default widths.
- One sub-module, rr_arbiter2:
  - two-input round-robin arbiter holding the last_grant register, with an enable input (asserted in IDLE);
  - outputs grant_valid and grant_id.

Test Plan:
- Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x010 with memory[0x010]=0xBEEF (MEM_LAT=2) → mem_read high in cycles 1–2, cpu_ready pulse in cycle 3 with cpu_rdata=0xBEEF; dma_ready stays 0.
- DMA write: addr 0x020, data 0x1234, then a CPU read of 0x020 → mem_write high for 2 cycles; CPU later reads 0x1234.
- cpu_req and dma_req both held high from reset for 4 accesses → grant_id sequence 0,1,0,1; each ready pulse lasts exactly 1 cycle; consecutive grants start 4 cycles apart.
- cpu_addr changed from 0x010 to 0x3FF while in ACCESS → mem_addr stays 0x010 for the whole access.
- reset asserted in the 1st ACCESS cycle of a DMA write → mem_write falls in the same cycle without waiting for clk; no ready pulse; state = IDLE after reset; next contention grants the CPU.
- MEM_LAT=1 build: isolated CPU read → strobe for 1 cycle, ready in cycle 2; busy is high in cycles 1–2 only.
